// File: rtl/multicycle_control_fsm.sv
// Main sequencing FSM of the multicycle RV32IM core: steps each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath selects and handshakes.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       resetn,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       mem_ready,
  input  logic       take_branch,
  input  logic       muldiv_ready,
  output logic       mem_valid,
  output logic       mem_we,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUOp,
  output logic       muldiv_valid,
  output logic       instret,
  output logic       trap
);

  localparam logic [2:0] ALU_OP_ADD         = 3'd0;
  localparam logic [2:0] ALU_OP_BRANCH      = 3'd1;
  localparam logic [2:0] ALU_OP_ARITH_LOGIC = 3'd2;
  localparam logic [2:0] ALU_OP_LUI         = 3'd3;
  localparam logic [2:0] ALU_OP_AUIPC       = 3'd4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // JALR's second cycle is identical to JAL (PC <= ALUOut, then OldPC+4 -> rd), so the two
  // share one state; LUI/AUIPC share one state selected by op[5]. That keeps 16 states in 4 bits.
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_LOAD, S_LOAD_WB, S_STORE, S_EXEC_R,
    S_EXEC_I, S_MULDIV, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_UPPER, S_TRAP
  } state_t;

  state_t state, next_state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state   = state;
    mem_valid    = 1'b0;
    mem_we       = 1'b0;
    AdrSrc       = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ResultSrc    = 2'b00;
    ALUOp        = ALU_OP_ADD;
    muldiv_valid = 1'b0;
    instret      = 1'b0;
    trap         = 1'b0;

    case (state)
      S_IDLE: next_state = S_FETCH;

      S_FETCH: begin
        mem_valid = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXEC_R;
          OP_I:              next_state = S_EXEC_I;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = (funct3 == 3'b000) ? S_JALR : S_TRAP;
          OP_LUI, OP_AUIPC:  next_state = S_UPPER;
          OP_FENCE: begin
            instret    = 1'b1;
            next_state = S_FETCH;
          end
          default:           next_state = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = op[5] ? S_STORE : S_LOAD;
      end

      S_LOAD: begin
        mem_valid = 1'b1;
        AdrSrc    = 1'b1;
        if (mem_ready) next_state = S_LOAD_WB;
      end

      S_LOAD_WB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instret    = 1'b1;
        next_state = S_FETCH;
      end

      S_STORE: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        AdrSrc    = 1'b1;
        if (mem_ready) begin
          instret    = 1'b1;
          next_state = S_FETCH;
        end
      end

      S_EXEC_R: begin
        ALUSrcA = 2'b10;
        ALUOp   = ALU_OP_ARITH_LOGIC;
        if (funct7 == 7'b0000001)                             next_state = S_MULDIV;
        else if (funct7 == 7'b0000000 || funct7 == 7'b0100000) next_state = S_ALU_WB;
        else                                                  next_state = S_TRAP;
      end

      S_EXEC_I: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = ALU_OP_ARITH_LOGIC;
        next_state = S_ALU_WB;
      end

      S_MULDIV: begin
        muldiv_valid = 1'b1;
        if (muldiv_ready) begin
          ResultSrc  = 2'b11;
          RegWrite   = 1'b1;
          instret    = 1'b1;
          next_state = S_FETCH;
        end
      end

      S_ALU_WB: begin
        RegWrite   = 1'b1;
        instret    = 1'b1;
        next_state = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUOp      = ALU_OP_BRANCH;
        PCWrite    = take_branch;
        instret    = 1'b1;
        next_state = S_FETCH;
      end

      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        next_state = S_ALU_WB;
      end

      S_JALR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = S_JAL;
      end

      S_UPPER: begin
        ALUSrcB = 2'b01;
        if (op[5]) begin
          ALUOp = ALU_OP_LUI;
        end else begin
          ALUOp   = ALU_OP_AUIPC;
          ALUSrcA = 2'b01;
        end
        next_state = S_ALU_WB;
      end

      S_TRAP: trap = 1'b1;

      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: each instruction is expanded into its expected per-cycle
// output script from the ISA-level sequencing rules, with random wait states and don't-care inputs.
module tb_multicycle_control_fsm;

  localparam logic [2:0] A_ADD = 3'd0, A_BR = 3'd1, A_AL = 3'd2, A_LUI = 3'd3, A_AUIPC = 3'd4;
  localparam int K_ADD = 0, K_MUL = 1, K_I = 2, K_LD = 3, K_ST = 4, K_BR = 5,
                 K_JAL = 6, K_JALR = 7, K_LUI = 8, K_AUIPC = 9, K_FENCE = 10;

  logic clk = 1'b0;
  logic resetn;
  logic [6:0] op, cur_op;
  logic [2:0] funct3, cur_f3;
  logic [6:0] funct7, cur_f7;
  logic mem_ready, take_branch, muldiv_ready;
  logic mem_valid, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, muldiv_valid, instret, trap;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ALUOp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .resetn(resetn), .op(op), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .take_branch(take_branch), .muldiv_ready(muldiv_ready),
    .mem_valid(mem_valid), .mem_we(mem_we), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUOp(ALUOp), .muldiv_valid(muldiv_valid),
    .instret(instret), .trap(trap)
  );

  // Expected-output word: {mem_valid,mem_we,AdrSrc,IRWrite,PCWrite,RegWrite,A,B,Result,ALUOp,muldiv_valid,instret,trap}
  function automatic logic [17:0] ex(input logic mv, we, adr, irw, pcw, rw,
                                     input logic [1:0] a, b, rs, input logic [2:0] aop,
                                     input logic mdv, ir, tr);
    return {mv, we, adr, irw, pcw, rw, a, b, rs, aop, mdv, ir, tr};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  logic [17:0] E_ZERO, E_FW, E_FGO, E_DEC, E_DEC_FENCE, E_EXR, E_EXI, E_MADR, E_LD, E_LDWB;
  logic [17:0] E_STW, E_STGO, E_MDW, E_MDGO, E_WB, E_JAL, E_JALR, E_LUI, E_AUIPC, E_TRAP;

  task automatic check(input logic [17:0] e, input string tag);
    logic [17:0] obs;
    obs = {mem_valid, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
           ResultSrc, ALUOp, muldiv_valid, instret, trap};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, e);
    end
  endtask

  task automatic step(input logic mr, tbr, mdr, input logic [17:0] e, input string tag);
    @(negedge clk);
    op = cur_op; funct3 = cur_f3; funct7 = cur_f7;
    mem_ready = mr; take_branch = tbr; muldiv_ready = mdr;
    #1 check(e, tag);
  endtask

  task automatic fetch(input int w);
    repeat (w) step(1'b0, rb(), rb(), E_FW, "fetch_wait");
    step(1'b1, rb(), rb(), E_FGO, "fetch_go");
  endtask

  task automatic run_instr(input int kind, input int fw, input int w, input logic tbv);
    cur_f3 = 3'($urandom_range(0, 7));
    cur_f7 = 7'($urandom_range(0, 127));
    case (kind)
      K_ADD:   begin cur_op = 7'b0110011; cur_f7 = rb() ? 7'b0100000 : 7'b0000000; end
      K_MUL:   begin cur_op = 7'b0110011; cur_f7 = 7'b0000001; end
      K_I:     cur_op = 7'b0010011;
      K_LD:    cur_op = 7'b0000011;
      K_ST:    cur_op = 7'b0100011;
      K_BR:    cur_op = 7'b1100011;
      K_JAL:   cur_op = 7'b1101111;
      K_JALR:  begin cur_op = 7'b1100111; cur_f3 = 3'b000; end
      K_LUI:   cur_op = 7'b0110111;
      K_AUIPC: cur_op = 7'b0010111;
      default: cur_op = 7'b0001111;
    endcase
    fetch(fw);
    step(rb(), rb(), rb(), (kind == K_FENCE) ? E_DEC_FENCE : E_DEC, "decode");
    case (kind)
      K_ADD: begin
        step(rb(), rb(), rb(), E_EXR, "exec_r");
        step(rb(), rb(), rb(), E_WB, "alu_wb");
      end
      K_MUL: begin
        step(rb(), rb(), rb(), E_EXR, "exec_r_mul");
        repeat (w) step(rb(), rb(), 1'b0, E_MDW, "muldiv_wait");
        step(rb(), rb(), 1'b1, E_MDGO, "muldiv_done");
      end
      K_I: begin
        step(rb(), rb(), rb(), E_EXI, "exec_i");
        step(rb(), rb(), rb(), E_WB, "alu_wb");
      end
      K_LD: begin
        step(rb(), rb(), rb(), E_MADR, "memadr_ld");
        repeat (w) step(1'b0, rb(), rb(), E_LD, "load_wait");
        step(1'b1, rb(), rb(), E_LD, "load_go");
        step(rb(), rb(), rb(), E_LDWB, "load_wb");
      end
      K_ST: begin
        step(rb(), rb(), rb(), E_MADR, "memadr_st");
        repeat (w) step(1'b0, rb(), rb(), E_STW, "store_wait");
        step(1'b1, rb(), rb(), E_STGO, "store_go");
      end
      K_BR:
        step(rb(), tbv, rb(), ex(0,0,0,0,tbv,0,2'b10,2'b00,2'b00,A_BR,0,1,0), "branch");
      K_JAL: begin
        step(rb(), rb(), rb(), E_JAL, "jal");
        step(rb(), rb(), rb(), E_WB, "jal_wb");
      end
      K_JALR: begin
        step(rb(), rb(), rb(), E_JALR, "jalr");
        step(rb(), rb(), rb(), E_JAL, "jalr_pc");
        step(rb(), rb(), rb(), E_WB, "jalr_wb");
      end
      K_LUI: begin
        step(rb(), rb(), rb(), E_LUI, "lui");
        step(rb(), rb(), rb(), E_WB, "lui_wb");
      end
      K_AUIPC: begin
        step(rb(), rb(), rb(), E_AUIPC, "auipc");
        step(rb(), rb(), rb(), E_WB, "auipc_wb");
      end
      default: ;
    endcase
  endtask

  // Async reset taken between edges; the core must be idle immediately and fetch next cycle.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #1 resetn = 1'b0;
    #1 check(E_ZERO, tag);
    #1 resetn = 1'b1;
    #1 check(E_ZERO, "idle_after_reset");
  endtask

  initial begin
    E_ZERO      = '0;
    E_FW        = ex(1,0,0,0,0,0,2'b00,2'b10,2'b10,A_ADD,0,0,0);
    E_FGO       = ex(1,0,0,1,1,0,2'b00,2'b10,2'b10,A_ADD,0,0,0);
    E_DEC       = ex(0,0,0,0,0,0,2'b01,2'b01,2'b00,A_ADD,0,0,0);
    E_DEC_FENCE = ex(0,0,0,0,0,0,2'b01,2'b01,2'b00,A_ADD,0,1,0);
    E_EXR       = ex(0,0,0,0,0,0,2'b10,2'b00,2'b00,A_AL,0,0,0);
    E_EXI       = ex(0,0,0,0,0,0,2'b10,2'b01,2'b00,A_AL,0,0,0);
    E_MADR      = ex(0,0,0,0,0,0,2'b10,2'b01,2'b00,A_ADD,0,0,0);
    E_LD        = ex(1,0,1,0,0,0,2'b00,2'b00,2'b00,A_ADD,0,0,0);
    E_LDWB      = ex(0,0,0,0,0,1,2'b00,2'b00,2'b01,A_ADD,0,1,0);
    E_STW       = ex(1,1,1,0,0,0,2'b00,2'b00,2'b00,A_ADD,0,0,0);
    E_STGO      = ex(1,1,1,0,0,0,2'b00,2'b00,2'b00,A_ADD,0,1,0);
    E_MDW       = ex(0,0,0,0,0,0,2'b00,2'b00,2'b00,A_ADD,1,0,0);
    E_MDGO      = ex(0,0,0,0,0,1,2'b00,2'b00,2'b11,A_ADD,1,1,0);
    E_WB        = ex(0,0,0,0,0,1,2'b00,2'b00,2'b00,A_ADD,0,1,0);
    E_JAL       = ex(0,0,0,0,1,0,2'b01,2'b10,2'b00,A_ADD,0,0,0);
    E_JALR      = ex(0,0,0,0,0,0,2'b10,2'b01,2'b00,A_ADD,0,0,0);
    E_LUI       = ex(0,0,0,0,0,0,2'b00,2'b01,2'b00,A_LUI,0,0,0);
    E_AUIPC     = ex(0,0,0,0,0,0,2'b01,2'b01,2'b00,A_AUIPC,0,0,0);
    E_TRAP      = ex(0,0,0,0,0,0,2'b00,2'b00,2'b00,A_ADD,0,0,1);

    resetn = 1'b0; mem_ready = 1'b1; take_branch = 1'b1; muldiv_ready = 1'b1;
    cur_op = 7'b0110011; cur_f3 = '0; cur_f7 = '0;
    op = cur_op; funct3 = cur_f3; funct7 = cur_f7;

    // Reset held three cycles with mem_ready high: everything quiet.
    repeat (3) begin
      @(negedge clk);
      #1 check(E_ZERO, "reset");
    end
    resetn = 1'b1;
    #1 check(E_ZERO, "idle");

    // Directed: zero-wait ADD, LW with 3 wait cycles, BEQ not-taken/taken, MUL with 5 wait cycles.
    run_instr(K_ADD, 0, 0, 1'b0);
    run_instr(K_LD, 0, 3, 1'b0);
    run_instr(K_BR, 0, 0, 1'b0);
    run_instr(K_BR, 0, 0, 1'b1);
    run_instr(K_MUL, 0, 5, 1'b0);
    run_instr(K_FENCE, 1, 0, 1'b0);

    // Randomized instruction stream with random fetch/memory/mul-div wait states.
    for (int n = 0; n < 60; n++)
      run_instr($urandom_range(0, 10), $urandom_range(0, 2), $urandom_range(0, 4), rb());

    // Reset in the middle of a load wait drops the request immediately.
    cur_op = 7'b0000011;
    fetch(0);
    step(rb(), rb(), rb(), E_DEC, "decode_ld");
    step(rb(), rb(), rb(), E_MADR, "memadr_ld");
    step(1'b0, rb(), rb(), E_LD, "load_wait");
    mem_ready = 1'b0;
    pulse_reset("reset_mid_load");
    run_instr(K_I, 0, 0, 1'b0);

    // Unsupported R-type funct7 traps after EXEC_R.
    cur_op = 7'b0110011; cur_f7 = 7'b0000011;
    fetch(0);
    step(rb(), rb(), rb(), E_DEC, "decode_badf7");
    step(rb(), rb(), rb(), E_EXR, "exec_r_badf7");
    repeat (3) step(rb(), rb(), rb(), E_TRAP, "trap_badf7");
    pulse_reset("reset_trap_badf7");

    // JALR with non-zero funct3 traps straight from DECODE.
    cur_op = 7'b1100111; cur_f3 = 3'b010;
    fetch(1);
    step(rb(), rb(), rb(), E_DEC, "decode_badjalr");
    repeat (3) step(rb(), rb(), rb(), E_TRAP, "trap_badjalr");
    pulse_reset("reset_trap_badjalr");

    // SYSTEM opcode traps and stays trapped for 20 cycles until reset, then refetches.
    cur_op = 7'b1110011;
    fetch(0);
    step(rb(), rb(), rb(), E_DEC, "decode_system");
    repeat (20) step(rb(), rb(), rb(), E_TRAP, "trap_sticky");
    pulse_reset("reset_trap_system");
    run_instr(K_ADD, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
